// File: rtl/paillier_job_sched_if.sv
// rtl/paillier_job_sched_if.sv - host-side job request / status response bundle for paillier_job_sched
interface paillier_job_sched_if #(
  parameter int TAG_W = 4
) ();
  logic             job_valid;
  logic             job_ready;
  logic [TAG_W-1:0] job_tag;
  logic             job_skip_pre;
  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [1:0]       res_err;

  modport master (
    output job_valid, job_tag, job_skip_pre, res_ready,
    input  job_ready, res_valid, res_tag, res_err
  );

  modport slave (
    input  job_valid, job_tag, job_skip_pre, res_ready,
    output job_ready, res_valid, res_tag, res_err
  );
endinterface

// File: rtl/paillier_job_sched.sv
// rtl/paillier_job_sched.sv - job sequencer for the Paillier modexp engine (pre/me/mm start levels, watchdog, status)
// Optional perf counters under PAILLIER_SCHED_PERF_EN.
module paillier_job_sched #(
  parameter int EN_HOLD   = 2,
  parameter int TIMEOUT_W = 20,
  parameter int TAG_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  paillier_job_sched_if.slave bus,
  output logic                eng_en_pre,
  output logic                eng_en_me,
  output logic                eng_en_mm,
  output logic [TAG_W-1:0]    eng_num,
  input  logic                eng_done,
  input  logic [TAG_W-1:0]    eng_num_out,
  output logic                busy,
  output logic                stray_done
`ifdef PAILLIER_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_jobs,
  output logic [47:0]         perf_cycles
`endif
);

  localparam int HOLD_W = (EN_HOLD > 1) ? $clog2(EN_HOLD) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(EN_HOLD - 1);
  // Timeout fires on the edge the watchdog would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE, PRE_ISS, PRE_WAIT, ME_ISS, ME_WAIT, MM_ISS, MM_WAIT, RESP
  } state_t;

  state_t               r_state;
  logic                 r_done_q;
  logic [TIMEOUT_W-1:0] r_wd;
  logic [HOLD_W-1:0]    r_hold;
  logic                 r_done_seen;
  logic [TAG_W-1:0]     r_tag;
  logic [1:0]           r_err;
  logic                 r_en_pre;
  logic                 r_en_me;
  logic                 r_en_mm;
  logic                 r_job_ready;
  logic                 r_res_valid;
  logic                 r_stray;

  logic   w_done_evt;
  logic   w_in_iss;
  logic   w_in_wait;
  logic   w_in_mm;
  logic   w_hold_last;
  logic   w_timeout;
  logic   w_advance;
  logic   w_to_wait;
  state_t w_next;
  state_t w_wait;

  assign w_done_evt  = eng_done ^ r_done_q;
  assign w_in_iss    = (r_state == PRE_ISS) || (r_state == ME_ISS) || (r_state == MM_ISS);
  assign w_in_wait   = (r_state == PRE_WAIT) || (r_state == ME_WAIT) || (r_state == MM_WAIT);
  assign w_in_mm     = (r_state == MM_ISS) || (r_state == MM_WAIT);
  assign w_hold_last = (r_hold == HOLD_LAST);

  // A done seen during issue is remembered; the pulse still runs its full length.
  assign w_timeout = (w_in_iss || w_in_wait) && !w_done_evt && !r_done_seen && (r_wd == WD_LAST);
  assign w_advance = (w_in_iss && w_hold_last && (r_done_seen || w_done_evt))
                   || (w_in_wait && w_done_evt);
  assign w_to_wait = w_in_iss && w_hold_last && !r_done_seen && !w_done_evt;

  always_comb begin
    w_next = RESP;
    w_wait = MM_WAIT;
    case (r_state)
      PRE_ISS, PRE_WAIT: begin w_next = ME_ISS; w_wait = PRE_WAIT; end
      ME_ISS, ME_WAIT:   begin w_next = MM_ISS; w_wait = ME_WAIT;  end
      default:           begin w_next = RESP;   w_wait = MM_WAIT;  end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_done_q    <= 1'b0;
      r_wd        <= '0;
      r_hold      <= '0;
      r_done_seen <= 1'b0;
      r_tag       <= '0;
      r_err       <= 2'b00;
      r_en_pre    <= 1'b0;
      r_en_me     <= 1'b0;
      r_en_mm     <= 1'b0;
      r_job_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_stray     <= 1'b0;
    end else begin
      r_done_q <= eng_done;
      if (w_done_evt && ((r_state == IDLE) || (r_state == RESP))) r_stray <= 1'b1;
      if (w_in_iss) r_hold <= r_hold + 1'b1;
      if (w_in_iss || w_in_wait) r_wd <= r_wd + 1'b1;
      if (w_in_iss && w_done_evt) r_done_seen <= 1'b1;
      if (w_in_mm && w_done_evt) r_err[1] <= (eng_num_out != r_tag);

      case (r_state)
        IDLE: begin
          if (bus.job_valid) begin
            r_tag       <= bus.job_tag;
            r_job_ready <= 1'b0;
            r_wd        <= '0;
            r_hold      <= '0;
            r_done_seen <= 1'b0;
            if (bus.job_skip_pre) begin
              r_state <= ME_ISS;
              r_en_me <= 1'b1;
            end else begin
              r_state  <= PRE_ISS;
              r_en_pre <= 1'b1;
            end
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_err       <= 2'b00;
            r_job_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          if (w_timeout) begin
            r_err[0]    <= 1'b1;
            r_en_pre    <= 1'b0;
            r_en_me     <= 1'b0;
            r_en_mm     <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= RESP;
          end else if (w_advance) begin
            r_state     <= w_next;
            r_wd        <= '0;
            r_hold      <= '0;
            r_done_seen <= 1'b0;
            r_en_pre    <= 1'b0;
            r_en_me     <= (w_next == ME_ISS);
            r_en_mm     <= (w_next == MM_ISS);
            r_res_valid <= (w_next == RESP);
          end else if (w_to_wait) begin
            r_en_pre <= 1'b0;
            r_en_me  <= 1'b0;
            r_en_mm  <= 1'b0;
            r_state  <= w_wait;
          end
        end
      endcase
    end
  end

  assign bus.job_ready = r_job_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_tag   = r_tag;
  assign bus.res_err   = r_err;
  assign eng_en_pre    = r_en_pre;
  assign eng_en_me     = r_en_me;
  assign eng_en_mm     = r_en_mm;
  assign eng_num       = r_tag;
  assign busy          = (r_state != IDLE);
  assign stray_done    = r_stray;

`ifdef PAILLIER_SCHED_PERF_EN
  logic [31:0] r_perf_jobs;
  logic [47:0] r_perf_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_jobs   <= '0;
      r_perf_cycles <= '0;
    end else begin
      if ((r_state == RESP) && bus.res_ready) r_perf_jobs <= r_perf_jobs + 32'd1;
      if (busy) r_perf_cycles <= r_perf_cycles + 48'd1;
    end
  end

  assign perf_jobs   = r_perf_jobs;
  assign perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_paillier_job_sched.sv
// tb/tb_paillier_job_sched.sv - randomized self-checking bench for paillier_job_sched against a job-level model
module tb_paillier_job_sched;
  localparam int TAG_W     = 4;
  localparam int EN_HOLD   = 2;
  localparam int TIMEOUT_W = 6;
  localparam int WD_LIMIT  = (1 << TIMEOUT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             eng_en_pre, eng_en_me, eng_en_mm;
  logic [TAG_W-1:0] eng_num;
  logic             eng_done = 1'b0;
  logic [TAG_W-1:0] eng_num_out = '0;
  logic             busy, stray_done;
`ifdef PAILLIER_SCHED_PERF_EN
  logic [31:0]      perf_jobs;
  logic [47:0]      perf_cycles;
`endif

  paillier_job_sched_if #(.TAG_W(TAG_W)) bus ();

  paillier_job_sched #(.EN_HOLD(EN_HOLD), .TIMEOUT_W(TIMEOUT_W), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .eng_en_pre  (eng_en_pre),
    .eng_en_me   (eng_en_me),
    .eng_en_mm   (eng_en_mm),
    .eng_num     (eng_num),
    .eng_done    (eng_done),
    .eng_num_out (eng_num_out),
    .busy        (busy),
    .stray_done  (stray_done)
`ifdef PAILLIER_SCHED_PERF_EN
    ,
    .perf_jobs   (perf_jobs),
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               last_rise_cyc = 0;
  int               seen_q[$];
  bit               exp_stray = 1'b0;
  int               eng_delay = 10;
  int               eng_hang = 0;
  logic [TAG_W-1:0] eng_ret = '0;
  int               eng_cd = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Engine: toggles done eng_delay cycles after each start rise, unless that phase hangs.
  initial begin
    bit         pv [3];
    logic [2:0] ln;
    pv = '{0, 0, 0};
    forever begin
      @(negedge clk);
      ln = {eng_en_mm, eng_en_me, eng_en_pre};
      if (!rst_n) begin
        eng_cd = 0;
        pv = '{0, 0, 0};
      end else begin
        if (eng_cd > 0) begin
          eng_cd--;
          if (eng_cd == 0) eng_done = ~eng_done;
        end
        for (int i = 0; i < 3; i++) begin
          if (ln[i] && !pv[i]) begin
            eng_num_out = eng_ret;
            if (eng_hang != i + 1) begin
              if (eng_delay == 0) eng_done = ~eng_done;
              else eng_cd = eng_delay;
            end
          end
          pv[i] = ln[i];
        end
      end
    end
  end

  // Start-line monitor: records phase order, pulse widths and exclusivity.
  initial begin
    int         w [3];
    bit         prv [3];
    logic [2:0] ln;
    w = '{0, 0, 0};
    prv = '{0, 0, 0};
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ln = {eng_en_mm, eng_en_me, eng_en_pre};
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          w[i] = 0;
          prv[i] = 0;
        end else begin
          if (ln[i]) begin
            if (!prv[i]) begin
              seen_q.push_back(i + 1);
              last_rise_cyc = cyc;
              chk("start_onehot", $countones(ln), 1);
            end
            w[i]++;
          end else if (prv[i]) begin
            chk("start_width", w[i], EN_HOLD);
            w[i] = 0;
          end
          prv[i] = ln[i];
        end
      end
    end
  end

  task automatic check_reset_state();
    chk("rst_job_ready", bus.job_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_tag", bus.res_tag, 0);
    chk("rst_res_err", bus.res_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stray", stray_done, 0);
    chk("rst_lines", {eng_en_pre, eng_en_me, eng_en_mm}, 0);
    chk("rst_eng_num", eng_num, 0);
  endtask

  task automatic run_job(input logic [TAG_W-1:0] tag, input bit skip, input int delay,
                         input int hang, input logic [TAG_W-1:0] ret, input int stall,
                         input bit poke);
    int         exp_q[$];
    bit         timed_out;
    logic [1:0] exp_err;
    int         n;
    bit         ok;
    timed_out = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      if (p == 1 && skip) continue;
      exp_q.push_back(p);
      if (p == hang) begin
        timed_out = 1'b1;
        break;
      end
    end
    exp_err = timed_out ? 2'b01 : ((ret != tag) ? 2'b10 : 2'b00);
    eng_delay = delay;
    eng_hang = hang;
    eng_ret = ret;
    seen_q.delete();

    n = 0;
    while (!bus.job_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("job_ready", bus.job_ready, 1);
    bus.job_valid = 1'b1;
    bus.job_tag = tag;
    bus.job_skip_pre = skip;
    @(negedge clk);
    bus.job_valid = 1'b0;
    chk("accept_num", eng_num, tag);
    chk("accept_ready", bus.job_ready, 0);

    n = 0;
    while (!bus.res_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("res_seen", bus.res_valid, 1);
    if (!bus.res_valid) return;
    chk("n_phases", seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
      chk("phase_order", seen_q[i], exp_q[i]);
    if (timed_out) chk("wd_latency", cyc - last_rise_cyc, WD_LIMIT);
    chk("res_tag", bus.res_tag, tag);
    chk("res_err", bus.res_err, exp_err);
    chk("lines_idle", {eng_en_pre, eng_en_me, eng_en_mm}, 0);

    if (stall > 0) begin
      bus.job_valid = 1'b1;
      bus.job_tag = ~tag;
      bus.job_skip_pre = 1'b0;
    end
    ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      ok = ok & bus.res_valid & (bus.res_tag == tag) & (bus.res_err == exp_err)
              & !bus.job_ready & (eng_num == tag);
    end
    if (stall > 0) chk("stall_hold", ok, 1);
    bus.job_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("post_hs_valid", bus.res_valid, 0);
    chk("post_hs_ready", bus.job_ready, 1);
    chk("post_hs_busy", busy, 0);
    if (poke) begin
      eng_done = ~eng_done;
      exp_stray = 1'b1;
      repeat (2) @(negedge clk);
    end
    chk("stray", stray_done, exp_stray);
  endtask

  task automatic reset_mid_job();
    int n;
    bit ok;
    eng_delay = 12;
    eng_hang = 0;
    eng_ret = 4'd6;
    seen_q.delete();
    bus.job_valid = 1'b1;
    bus.job_tag = 4'd6;
    bus.job_skip_pre = 1'b0;
    @(negedge clk);
    bus.job_valid = 1'b0;
    n = 0;
    while (!(seen_q.size() == 2 && !eng_en_me) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("reach_me_wait", seen_q.size(), 2);
    rst_n = 1'b0;
    eng_done = 1'b0;
    exp_stray = 1'b0;
    #1;
    check_reset_state();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      ok = ok & !bus.res_valid & !busy;
    end
    chk("no_spurious", ok, 1);
  endtask

  initial begin
    logic [TAG_W-1:0] t, r;
    int               h;
    bit               s;
    bus.job_valid = 1'b0;
    bus.job_tag = '0;
    bus.job_skip_pre = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    @(negedge clk);

    run_job(4'd5, 1'b0, 10, 0, 4'd5, 0, 1'b0);
    run_job(4'd3, 1'b1, 10, 0, 4'd3, 0, 1'b0);
    run_job(4'd7, 1'b0, 10, 2, 4'd7, 0, 1'b1);
    run_job(4'd2, 1'b0, 6, 0, 4'd9, 0, 1'b0);
    run_job(4'd11, 1'b0, 4, 0, 4'd11, 20, 1'b0);
    run_job(4'd1, 1'b0, 0, 0, 4'd1, 1, 1'b0);
    reset_mid_job();
    run_job(4'd12, 1'b0, 10, 0, 4'd12, 1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      t = TAG_W'($urandom_range(0, 15));
      s = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      r = ($urandom_range(0, 3) == 0) ? (t ^ TAG_W'($urandom_range(1, 15))) : t;
      run_job(t, s, int'($urandom_range(0, 12)), h, r, int'($urandom_range(0, 4)),
              (h != 0) && !(h == 1 && s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got %0d cycles expected fewer", cyc);
    $fatal(1, "global timeout");
  end
endmodule
